branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor feeding the fetch-redirect path and the hazard unit's BranchMissed input. Direct-mapped branch target buffer (BTB) with 2-bit saturating counters, read in Fetch and carried through Decode. Resolves in Execute against the actual outcome and raises BranchMissed with a corrected PC. Updates the table at the Execute clock edge.

## Interface
- ENTRIES, 16: number of BTB entries, power of two.
- IDX_W, log2(ENTRIES): index width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- PCF  in  32  fetch PC (word-aligned).
- StallF  in  1  from hazard unit; unused except for documentation of hold (PCF is held externally).
- StallD  in  1  hold the F→D metadata register.
- FlushD  in  1  clear the F→D metadata register.
- FlushE  in  1  clear the D→E metadata register.
- BranchE  in  1  instruction in Execute is a branch.
- ActualTakenE  in  1  branch condition passed in Execute.
- ActualTargetE  in  32  computed branch target in Execute.
- PredTakenF  out  1  select PredTargetF as next PC.
- PredTargetF  out  32  predicted target.
- BranchMissed  out  1  misprediction in Execute, to hazard unit.
- CorrectPCE  out  32  redirect PC, valid when BranchMissed=1.

## Operation
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2].
- Counter states: SN=0, WN=1, WT=2, ST=3.
- Fetch lookup is combinational: hit = valid & tag match. PredTakenF = hit & ctr[1]. PredTargetF = stored target on hit, else 0.
- F→D register {vD, predTakenD, predTargetD, PCD}:
  - loads {1, PredTakenF, PredTargetF, PCF} when StallD=0;
  - holds when StallD=1;
  - clears vD when FlushD=1 or BranchMissed=1, with priority over the stall.
- D→E register {vE, predTakenE, predTargetE, PCE}:
  - loads from D every cycle;
  - clears vE when FlushE=1 or BranchMissed=1.
- Misprediction, all evaluated combinationally in Execute:
  - vE & BranchE & (ActualTakenE ≠ predTakenE) → missed.
  - vE & BranchE & ActualTakenE & predTakenE & (ActualTargetE ≠ predTargetE) → missed.
  - vE & !BranchE & predTakenE (alias hit on a non-branch) → missed.
- CorrectPCE = ActualTargetE if (BranchE & ActualTakenE), else PCE+4 (32-bit wrap). It is 0 when BranchMissed=0.
- Table update at the clock edge, only when vE=1:
  - branch, hit: ctr increments saturating if taken, decrements saturating if not taken; target is overwritten with ActualTargetE if taken.
  - branch, miss, taken: allocate (replace) with valid=1, tag, target, ctr=WT.
  - branch, miss, not taken: no write.
  - non-branch with predTakenE=1: clear that entry's valid.
- The hit/miss decision for the update is re-evaluated in Execute on PCE, not carried from Fetch.

## Timing
- Reset, asynchronous: all valid bits, vD and vE cleared; all ctr set to WN. Outputs after reset: PredTakenF=0, PredTargetF=0, BranchMissed=0, CorrectPCE=0.
- Prediction latency 0 cycles (same cycle as PCF). Resolution is 2 cycles after fetch if unstalled.
- Table write and Fetch read to the same index in the same cycle: Fetch sees the old contents (no bypass).
- BranchMissed together with StallD=1: the flush wins, and vD is cleared.
- Reset asserted mid-operation: the in-flight update is abandoned and no partial write occurs.

## Structure
- Package bp_pkg holds:
  - ctr_t enum {SN, WN, WT, ST};
  - btb_entry_t struct {valid, tag, target, ctr};
  - function sat_update(ctr_t, taken).
- Sub-module btb_array: ENTRIES registers with one asynchronous read port (Fetch), one asynchronous read port (Execute) and one synchronous write port, with async active-low clear.
- Top level: the two metadata registers, mispredict compare, and update control.

## Test plan
- Cold BTB, taken branch at PC 0x100 to 0x200 → Execute: BranchMissed=1, CorrectPCE=0x200; next fetch of 0x100 gives PredTakenF=1, PredTargetF=0x200.
- Same branch not taken twice from WT → first: BranchMissed=1, CorrectPCE=0x104, ctr=WN; second: PredTakenF=0, no miss, ctr=SN.
- Taken four times from WT → ctr saturates at ST, and BranchMissed=0 on each.
- Alias: non-branch at 0x140 (same index as 0x100, ENTRIES=16) predicted taken → BranchMissed=1, CorrectPCE=0x144, entry invalidated.
- StallD=1 for 2 cycles then FlushE → predTaken metadata held, then squashed; no table write, BranchMissed=0.
- Reset pulse while a mispredicted branch is in Execute → outputs 0 immediately; the entry is not allocated.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: counter encoding, BTB entry layout
// and the saturating counter step.
package bp_pkg;

    typedef enum logic [1:0] {
        SN = 2'd0,
        WN = 2'd1,
        WT = 2'd2,
        ST = 2'd3
    } ctr_t;

    // Tag is kept at full width (PC >> (IDX_W+2), zero-extended) so the
    // struct does not depend on the table size.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_RESET = '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: WN};

    function automatic ctr_t sat_update(ctr_t c, logic taken);
        ctr_t r;
        r = c;
        case (c)
            SN: r = taken ? WN : SN;
            WN: r = taken ? WT : SN;
            WT: r = taken ? ST : WN;
            ST: r = taken ? ST : WT;
            default: r = WN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/Execute side signals of the branch predictor. Inputs are sampled
// level-wise every cycle; there is no valid/ready handshake on this bus.
interface bp_if;
    logic [31:0] PCF;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        BranchE;
    logic        ActualTakenE;
    logic [31:0] ActualTargetE;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchMissed;
    logic [31:0] CorrectPCE;

    modport master (
        output PCF, StallF, StallD, FlushD, FlushE,
        output BranchE, ActualTakenE, ActualTargetE,
        input  PredTakenF, PredTargetF, BranchMissed, CorrectPCE
    );

    modport slave (
        input  PCF, StallF, StallD, FlushD, FlushE,
        input  BranchE, ActualTakenE, ActualTargetE,
        output PredTakenF, PredTargetF, BranchMissed, CorrectPCE
    );
endinterface

// File: rtl/branch_predictor_btb_array.sv
// BTB storage: two asynchronous read ports (Fetch, Execute) and one
// synchronous write port, cleared by the asynchronous active-low reset.
module btb_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx_f,
    output btb_entry_t       o_rd_f,
    input  logic [IDX_W-1:0] i_rd_idx_e,
    output btb_entry_t       o_rd_e,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  btb_entry_t       i_wr_data
);

    btb_entry_t r_mem [ENTRIES];

    // Reads see the pre-edge contents, so a same-cycle write is not bypassed.
    assign o_rd_f = r_mem[i_rd_idx_f];
    assign o_rd_e = r_mem[i_rd_idx_e];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= BTB_RESET;
            end
        end else if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: Fetch-time BTB lookup, F->D and D->E prediction
// metadata, Execute-time misprediction detection and table update.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic clk,
    input  logic reset,
    bp_if.slave  bus
);

    btb_entry_t       w_ent_f;
    btb_entry_t       w_ent_e;
    btb_entry_t       w_wr_data;
    logic             w_we;
    logic [IDX_W-1:0] w_idx_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [31:0]      w_tag_f;
    logic [31:0]      w_tag_e;
    logic             w_hit_f;
    logic             w_hit_e;
    logic             w_missed;
    logic             w_act_taken;
    logic             w_unused_stall_f;

    logic             r_vD;
    logic             r_pred_taken_d;
    logic [31:0]      r_pred_target_d;
    logic [31:0]      r_pc_d;
    logic             r_vE;
    logic             r_pred_taken_e;
    logic [31:0]      r_pred_target_e;
    logic [31:0]      r_pc_e;

    // PCF is held upstream during a Fetch stall, so StallF needs no logic here.
    assign w_unused_stall_f = bus.StallF;

    assign w_idx_f = bus.PCF[IDX_W+1:2];
    assign w_tag_f = {{(IDX_W+2){1'b0}}, bus.PCF[31:IDX_W+2]};
    assign w_idx_e = r_pc_e[IDX_W+1:2];
    assign w_tag_e = {{(IDX_W+2){1'b0}}, r_pc_e[31:IDX_W+2]};

    btb_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx_f (w_idx_f),
        .o_rd_f     (w_ent_f),
        .i_rd_idx_e (w_idx_e),
        .o_rd_e     (w_ent_e),
        .i_we       (w_we),
        .i_wr_idx   (w_idx_e),
        .i_wr_data  (w_wr_data)
    );

    assign w_hit_f         = w_ent_f.valid && (w_ent_f.tag == w_tag_f);
    assign bus.PredTakenF  = w_hit_f && (w_ent_f.ctr inside {WT, ST});
    assign bus.PredTargetF = w_hit_f ? w_ent_f.target : 32'd0;

    // A misprediction squashes the younger instruction in Decode even when
    // Decode is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vD            <= 1'b0;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= 32'd0;
            r_pc_d          <= 32'd0;
        end else if (bus.FlushD || w_missed) begin
            r_vD            <= 1'b0;
        end else if (!bus.StallD) begin
            r_vD            <= 1'b1;
            r_pred_taken_d  <= bus.PredTakenF;
            r_pred_target_d <= bus.PredTargetF;
            r_pc_d          <= bus.PCF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vE            <= 1'b0;
            r_pred_taken_e  <= 1'b0;
            r_pred_target_e <= 32'd0;
            r_pc_e          <= 32'd0;
        end else begin
            r_vE            <= r_vD && !(bus.FlushE || w_missed);
            r_pred_taken_e  <= r_pred_taken_d;
            r_pred_target_e <= r_pred_target_d;
            r_pc_e          <= r_pc_d;
        end
    end

    assign w_act_taken = bus.BranchE && bus.ActualTakenE;

    assign w_missed = r_vE && (
          (bus.BranchE && (bus.ActualTakenE != r_pred_taken_e))
        || (w_act_taken && r_pred_taken_e && (bus.ActualTargetE != r_pred_target_e))
        || (!bus.BranchE && r_pred_taken_e));

    assign bus.BranchMissed = w_missed;
    assign bus.CorrectPCE   = !w_missed   ? 32'd0 :
                              w_act_taken ? bus.ActualTargetE : (r_pc_e + 32'd4);

    // Hit is recomputed on PCE because the entry may have changed since Fetch.
    assign w_hit_e = w_ent_e.valid && (w_ent_e.tag == w_tag_e);

    always_comb begin
        w_we      = 1'b0;
        w_wr_data = w_ent_e;
        if (r_vE) begin
            if (bus.BranchE) begin
                if (w_hit_e) begin
                    w_we          = 1'b1;
                    w_wr_data.ctr = sat_update(w_ent_e.ctr, bus.ActualTakenE);
                    if (bus.ActualTakenE) begin
                        w_wr_data.target = bus.ActualTargetE;
                    end
                end else if (bus.ActualTakenE) begin
                    w_we      = 1'b1;
                    w_wr_data = '{valid: 1'b1, tag: w_tag_e, target: bus.ActualTargetE, ctr: WT};
                end
            end else if (r_pred_taken_e) begin
                w_we            = 1'b1;
                w_wr_data.valid = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter walk, target
// change, alias invalidation, stall/flush handling and mid-flight reset.
module tb_branch_predictor;

  localparam logic [31:0] FILL = 32'h0000_0804;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bp_if u_if ();

  branch_predictor #(.ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exec();
    u_if.BranchE       = 1'b0;
    u_if.ActualTakenE  = 1'b0;
    u_if.ActualTargetE = 32'd0;
  endtask

  // One instruction through F, D, E with filler behind it.
  task automatic issue(input string tag, input logic [31:0] pc, input logic br,
                       input logic taken, input logic [31:0] tgt,
                       input logic exp_pt, input logic [31:0] exp_ptg,
                       input logic exp_miss, input logic [31:0] exp_cpc);
    u_if.PCF = pc;
    #1;
    chk({tag, "_pred_taken"}, {31'd0, u_if.PredTakenF}, {31'd0, exp_pt});
    chk({tag, "_pred_target"}, u_if.PredTargetF, exp_ptg);
    tick();
    u_if.PCF = FILL;
    tick();
    u_if.BranchE       = br;
    u_if.ActualTakenE  = taken;
    u_if.ActualTargetE = tgt;
    #1;
    chk({tag, "_missed"}, {31'd0, u_if.BranchMissed}, {31'd0, exp_miss});
    chk({tag, "_correct_pc"}, u_if.CorrectPCE, exp_cpc);
    tick();
    clear_exec();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    u_if.PCF    = 32'h100;
    u_if.StallF = 1'b0;
    u_if.StallD = 1'b0;
    u_if.FlushD = 1'b0;
    u_if.FlushE = 1'b0;
    clear_exec();
    #2;
    chk("rst_pred_taken", {31'd0, u_if.PredTakenF}, 32'd0);
    chk("rst_pred_target", u_if.PredTargetF, 32'd0);
    chk("rst_missed", {31'd0, u_if.BranchMissed}, 32'd0);
    chk("rst_correct_pc", u_if.CorrectPCE, 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Cold allocate, then the WT -> WN -> SN -> WN -> WT walk.
    issue("cold_taken", 32'h100, 1, 1, 32'h200, 0, 32'h0,   1, 32'h200);
    issue("wt_nt",      32'h100, 1, 0, 32'h0,   1, 32'h200, 1, 32'h104);
    issue("wn_nt",      32'h100, 1, 0, 32'h0,   0, 32'h200, 0, 32'h0);
    issue("sn_taken",   32'h100, 1, 1, 32'h200, 0, 32'h200, 1, 32'h200);
    issue("wn_taken",   32'h100, 1, 1, 32'h200, 0, 32'h200, 1, 32'h200);
    // Four taken from WT: saturates at ST, all correctly predicted.
    for (int i = 0; i < 4; i++) begin
      issue($sformatf("sat_%0d", i), 32'h100, 1, 1, 32'h200, 1, 32'h200, 0, 32'h0);
    end
    issue("st_nt",      32'h100, 1, 0, 32'h0,   1, 32'h200, 1, 32'h104);
    issue("new_target", 32'h100, 1, 1, 32'h300, 1, 32'h200, 1, 32'h300);

    // Same index, different tag: no prediction.
    u_if.PCF = 32'h140;
    #1;
    chk("tag_alias_pred", {31'd0, u_if.PredTakenF}, 32'd0);
    chk("tag_alias_target", u_if.PredTargetF, 32'd0);

    // Non-branch predicted taken: redirect to PC+4 and invalidate.
    issue("nonbr_alias", 32'h100, 0, 0, 32'h0, 1, 32'h300, 1, 32'h104);
    issue("after_inval", 32'h100, 1, 0, 32'h0, 0, 32'h0,   0, 32'h0);
    issue("realloc",     32'h100, 1, 1, 32'h200, 0, 32'h0, 1, 32'h200);

    // Stall D for two cycles with bubbles in E; held prediction then resolves.
    u_if.PCF = 32'h100;
    #1;
    chk("hold_fetch_pred", {31'd0, u_if.PredTakenF}, 32'd1);
    tick();
    u_if.PCF    = FILL;
    u_if.StallD = 1'b1;
    u_if.FlushE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("hold_stall_%0d", i), {31'd0, u_if.BranchMissed}, 32'd0);
      tick();
    end
    u_if.StallD = 1'b0;
    u_if.FlushE = 1'b0;
    tick();
    u_if.BranchE       = 1'b1;
    u_if.ActualTakenE  = 1'b1;
    u_if.ActualTargetE = 32'h200;
    #1;
    chk("hold_resolve_missed", {31'd0, u_if.BranchMissed}, 32'd0);
    chk("hold_resolve_cpc", u_if.CorrectPCE, 32'd0);
    tick();
    clear_exec();

    // Stall two cycles, then FlushE squashes the held entry: no table write.
    u_if.PCF = 32'h100;
    tick();
    u_if.PCF    = FILL;
    u_if.StallD = 1'b1;
    u_if.FlushE = 1'b1;
    tick();
    tick();
    u_if.StallD = 1'b0;
    tick();
    u_if.FlushE        = 1'b0;
    u_if.BranchE       = 1'b1;
    u_if.ActualTakenE  = 1'b1;
    u_if.ActualTargetE = 32'h400;
    #1;
    chk("squash_missed", {31'd0, u_if.BranchMissed}, 32'd0);
    tick();
    clear_exec();

    // Target must still be 0x200; then a miss with StallD=1 must clear D.
    u_if.PCF = 32'h100;
    #1;
    chk("squash_no_write_pred", {31'd0, u_if.PredTakenF}, 32'd1);
    chk("squash_no_write_target", u_if.PredTargetF, 32'h200);
    tick();
    tick();
    u_if.PCF           = FILL;
    u_if.StallD        = 1'b1;
    u_if.BranchE       = 1'b1;
    u_if.ActualTakenE  = 1'b1;
    u_if.ActualTargetE = 32'h500;
    #1;
    chk("miss_stall_missed", {31'd0, u_if.BranchMissed}, 32'd1);
    chk("miss_stall_cpc", u_if.CorrectPCE, 32'h500);
    tick();
    u_if.StallD = 1'b0;
    clear_exec();
    #1;
    chk("miss_stall_next", {31'd0, u_if.BranchMissed}, 32'd0);
    tick();
    chk("miss_stall_d_flushed", {31'd0, u_if.BranchMissed}, 32'd0);
    tick();

    // Reset while a mispredicted branch sits in Execute.
    u_if.PCF = 32'h208;
    tick();
    u_if.PCF = FILL;
    tick();
    u_if.BranchE       = 1'b1;
    u_if.ActualTakenE  = 1'b1;
    u_if.ActualTargetE = 32'h600;
    #1;
    chk("rst_mid_missed_before", {31'd0, u_if.BranchMissed}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_missed", {31'd0, u_if.BranchMissed}, 32'd0);
    chk("rst_mid_cpc", u_if.CorrectPCE, 32'd0);
    u_if.PCF = 32'h100;
    #1;
    chk("rst_mid_clears_table", {31'd0, u_if.PredTakenF}, 32'd0);
    tick();
    clear_exec();
    reset = 1'b1;
    tick();
    u_if.PCF = 32'h208;
    #1;
    chk("rst_no_alloc_pred", {31'd0, u_if.PredTakenF}, 32'd0);
    chk("rst_no_alloc_target", u_if.PredTargetF, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
